dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: the core memory stage
//  (port c: loads, stores, AMO read-modify-write) and a secondary master (port d: DMA/debug).

---
 rtl/dmem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Single-port data memory arbiter between the core memory
//                stage (port c, with AMO lock) and a DMA/debug master (port d).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int LOCK_TIMEOUT = 8,
   localparam int MASK_SIZE   = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  c_req,
   input  logic                  c_we,
   input  logic                  c_lock,
   input  logic [ADDR_WIDTH-1:0] c_addr,
   input  logic [DATA_WIDTH-1:0] c_wdata,
   input  logic [MASK_SIZE-1:0]  c_mask,
   output logic                  c_gnt,
   output logic                  c_rvalid,
   output logic [DATA_WIDTH-1:0] c_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   input  logic [MASK_SIZE-1:0]  d_mask,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  m_en,
   output logic                  m_we,
   output logic [ADDR_WIDTH-1:0] m_addr,
   output logic [DATA_WIDTH-1:0] m_wdata,
   output logic [MASK_SIZE-1:0]  m_mask,
   input  logic [DATA_WIDTH-1:0] m_rdata,
   output logic                  lock_err
);

   localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
   localparam int LOCK_W = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] c_STARVE  = WAIT_W'(STARVE_LIMIT);
   localparam logic [LOCK_W-1:0] c_LOCK_TO = LOCK_W'(LOCK_TIMEOUT);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_LOCKED = 1'b1;

   logic [0:0]        r_state;
   logic [0:0]        w_state_nxt;
   logic [WAIT_W-1:0] r_d_wait_cnt;
   logic [LOCK_W-1:0] r_lock_cnt;
   logic [LOCK_W-1:0] w_lock_cnt_inc;
   logic              w_lock_timeout;
   logic              w_c_gnt;
   logic              w_d_gnt;
   logic              r_c_rvalid;
   logic              r_d_rvalid;
   logic              r_lock_err;

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt    = r_state;
      w_lock_timeout = 1'b0;
      w_lock_cnt_inc = r_lock_cnt + 1'b1;
      case (r_state)
         S_IDLE: begin
            if (w_c_gnt && c_lock && !c_we) w_state_nxt = S_LOCKED;
         end
         S_LOCKED: begin
            if (w_c_gnt && c_we) begin
               w_state_nxt = S_IDLE;
            end else if (w_c_gnt && c_lock) begin
               w_state_nxt = S_LOCKED;
            end else if (w_lock_cnt_inc == c_LOCK_TO) begin
               w_state_nxt    = S_IDLE;
               w_lock_timeout = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Grant logic; the core always wins a tie unless d has waited STARVE_LIMIT cycles
   always_comb begin
      w_c_gnt = 1'b0;
      w_d_gnt = 1'b0;
      if (!rst) begin
         case (r_state)
            S_IDLE: begin
               if (c_req && d_req) begin
                  if (r_d_wait_cnt == c_STARVE) w_d_gnt = 1'b1;
                  else                          w_c_gnt = 1'b1;
               end else begin
                  w_c_gnt = c_req;
                  w_d_gnt = d_req;
               end
            end
            S_LOCKED: w_c_gnt = c_req;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !d_req || w_d_gnt)   r_d_wait_cnt <= '0;
      else if (r_d_wait_cnt != c_STARVE) r_d_wait_cnt <= r_d_wait_cnt + 1'b1;
   end

   // Locked reads restart the window; leaving LOCKED always clears it
   always_ff @(posedge clk) begin
      if (rst)
         r_lock_cnt <= '0;
      else if (r_state == S_LOCKED && w_state_nxt == S_LOCKED && !(w_c_gnt && c_lock))
         r_lock_cnt <= w_lock_cnt_inc;
      else
         r_lock_cnt <= '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_c_rvalid <= 1'b0;
         r_d_rvalid <= 1'b0;
         r_lock_err <= 1'b0;
      end else begin
         r_c_rvalid <= w_c_gnt && !c_we;
         r_d_rvalid <= w_d_gnt && !d_we;
         r_lock_err <= w_lock_timeout;
      end
   end

   // Gating with rst suppresses a read response already in flight when reset hits
   assign c_gnt    = w_c_gnt;
   assign d_gnt    = w_d_gnt;
   assign c_rvalid = r_c_rvalid && !rst;
   assign d_rvalid = r_d_rvalid && !rst;
   assign c_rdata  = c_rvalid ? m_rdata : '0;
   assign d_rdata  = d_rvalid ? m_rdata : '0;
   assign lock_err = r_lock_err && !rst;

   always_comb begin
      m_en    = w_c_gnt || w_d_gnt;
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      m_mask  = '0;
      if (w_c_gnt) begin
         m_we    = c_we;
         m_addr  = c_addr;
         m_wdata = c_wdata;
         m_mask  = c_mask;
      end else if (w_d_gnt) begin
         m_we    = d_we;
         m_addr  = d_addr;
         m_wdata = d_wdata;
         m_mask  = d_mask;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Directed self-checking bench for dmem_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        c_req, c_we, c_lock, c_gnt, c_rvalid;
   logic [31:0] c_addr, c_wdata, c_rdata;
   logic [3:0]  c_mask;
   logic        d_req, d_we, d_gnt, d_rvalid;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_mask;
   logic        m_en, m_we, lock_err;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_mask;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk(clk), .rst(rst),
      .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_mask(c_mask), .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_mask(m_mask),
      .m_rdata(m_rdata), .lock_err(lock_err)
   );

   // Memory model: untouched words read back as a value derived from their index
   logic [31:0] mem [0:255];
   bit   [255:0] mem_wr;
   logic [31:0] mem_w;

   function automatic logic [31:0] init_word(input logic [7:0] idx);
      return (idx == 8'h40) ? 32'hDEADBEEF : {24'hC0FFEE, idx};
   endfunction

   always @(posedge clk) begin
      if (m_en) begin
         mem_w = mem_wr[m_addr[9:2]] ? mem[m_addr[9:2]] : init_word(m_addr[9:2]);
         if (m_we) begin
            for (int b = 0; b < 4; b++)
               if (m_mask[b]) mem_w[8*b +: 8] = m_wdata[8*b +: 8];
            mem[m_addr[9:2]]    <= mem_w;
            mem_wr[m_addr[9:2]] <= 1'b1;
         end else begin
            m_rdata <= mem_w;
         end
      end
   end

   task automatic drive(input logic cr, input logic cw, input logic cl, input logic [31:0] ca,
                        input logic [31:0] cd, input logic [3:0] cm,
                        input logic dr, input logic dw, input logic [31:0] da);
      c_req = cr; c_we = cw; c_lock = cl; c_addr = ca; c_wdata = cd; c_mask = cm;
      d_req = dr; d_we = dw; d_addr = da; d_wdata = 32'h0; d_mask = 4'hF;
   endtask

   task automatic next_cycle;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      drive(1, 0, 0, 32'h100, 0, 4'hF, 1, 0, 32'h80);
      next_cycle();
      @(negedge clk);
      n_checks++; if (c_gnt !== 1'b0 || d_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got c=%b d=%b exp 0 0", c_gnt, d_gnt); end
      n_checks++; if (m_en !== 1'b0 || m_we !== 1'b0 || m_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem: got en=%b we=%b addr=%h exp 0 0 0", m_en, m_we, m_addr); end
      n_checks++; if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0 || lock_err !== 1'b0) begin n_fail++; $display("FAIL reset_out: got crv=%b drv=%b err=%b exp 0 0 0", c_rvalid, d_rvalid, lock_err); end
      next_cycle();
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      next_cycle();
   endtask

   task automatic test_read;
      drive(1, 0, 0, 32'h100, 0, 4'hF, 0, 0, 0);
      @(negedge clk);
      n_checks++; if (c_gnt !== 1'b1 || m_en !== 1'b1 || m_we !== 1'b0) begin n_fail++; $display("FAIL rd_grant: got gnt=%b en=%b we=%b exp 1 1 0", c_gnt, m_en, m_we); end
      n_checks++; if (m_addr !== 32'h100) begin n_fail++; $display("FAIL rd_addr: got %h exp 00000100", m_addr); end
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      n_checks++; if (c_rvalid !== 1'b1 || c_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got rv=%b data=%h exp 1 deadbeef", c_rvalid, c_rdata); end
      n_checks++; if (d_rvalid !== 1'b0 || m_en !== 1'b0) begin n_fail++; $display("FAIL rd_other: got drv=%b en=%b exp 0 0", d_rvalid, m_en); end
      next_cycle();
      @(negedge clk);
      n_checks++; if (c_rvalid !== 1'b0 || c_rdata !== 32'h0) begin n_fail++; $display("FAIL rd_pulse: got rv=%b data=%h exp 0 0", c_rvalid, c_rdata); end
      next_cycle();
   endtask

   task automatic test_write_mask;
      drive(1, 1, 1, 32'h104, 32'h0000AB00, 4'b0010, 0, 0, 0);
      @(negedge clk);
      n_checks++; if (c_gnt !== 1'b1 || m_we !== 1'b1 || m_mask !== 4'b0010 || m_wdata !== 32'h0000AB00) begin n_fail++; $display("FAIL wr_bus: got gnt=%b we=%b mask=%b data=%h exp 1 1 0010 0000ab00", c_gnt, m_we, m_mask, m_wdata); end
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 1, 0, 32'h104);
      @(negedge clk);
      n_checks++; if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rvalid: got c=%b d=%b exp 0 0", c_rvalid, d_rvalid); end
      n_checks++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_lock_ignored: got d_gnt=%b exp 1", d_gnt); end
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      n_checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hC0FFAB41) begin n_fail++; $display("FAIL wr_readback: got rv=%b data=%h exp 1 c0ffab41", d_rvalid, d_rdata); end
      next_cycle();
   endtask

   task automatic test_starve;
      logic exp_c, prev_c, prev_d;
      prev_c = 1'b0; prev_d = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive(1, 0, 0, 32'h100, 0, 4'hF, 1, 0, 32'h80);
         exp_c = ((i % 5) != 4);
         @(negedge clk);
         n_checks++; if (c_gnt !== exp_c || d_gnt !== !exp_c) begin n_fail++; $display("FAIL starve_gnt[%0d]: got c=%b d=%b exp %b %b", i, c_gnt, d_gnt, exp_c, !exp_c); end
         n_checks++; if (c_rvalid !== prev_c || d_rvalid !== prev_d) begin n_fail++; $display("FAIL starve_rvalid[%0d]: got c=%b d=%b exp %b %b", i, c_rvalid, d_rvalid, prev_c, prev_d); end
         if (prev_c) begin
            n_checks++; if (c_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL starve_cdata[%0d]: got %h exp deadbeef", i, c_rdata); end
         end
         prev_c = exp_c; prev_d = !exp_c;
         next_cycle();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      n_checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hC0FFEE20) begin n_fail++; $display("FAIL starve_ddata: got rv=%b data=%h exp 1 c0ffee20", d_rvalid, d_rdata); end
      next_cycle();
   endtask

   task automatic test_amo;
      drive(1, 0, 1, 32'h40, 0, 4'hF, 1, 0, 32'h80);
      @(negedge clk);
      n_checks++; if (c_gnt !== 1'b1 || d_gnt !== 1'b0) begin n_fail++; $display("FAIL amo_rd: got c=%b d=%b exp 1 0", c_gnt, d_gnt); end
      next_cycle();
      for (int i = 1; i < 3; i++) begin
         drive(0, 0, 0, 0, 0, 0, 1, 0, 32'h80);
         @(negedge clk);
         n_checks++; if (d_gnt !== 1'b0) begin n_fail++; $display("FAIL amo_locked[%0d]: got d_gnt=%b exp 0", i, d_gnt); end
         if (i == 1) begin
            n_checks++; if (c_rvalid !== 1'b1 || c_rdata !== 32'hC0FFEE10) begin n_fail++; $display("FAIL amo_rdata: got rv=%b data=%h exp 1 c0ffee10", c_rvalid, c_rdata); end
         end
         next_cycle();
      end
      drive(1, 1, 0, 32'h40, 32'h12345678, 4'hF, 1, 0, 32'h80);
      @(negedge clk);
      n_checks++; if (c_gnt !== 1'b1 || d_gnt !== 1'b0 || m_we !== 1'b1) begin n_fail++; $display("FAIL amo_wr: got c=%b d=%b we=%b exp 1 0 1", c_gnt, d_gnt, m_we); end
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 1, 0, 32'h80);
      @(negedge clk);
      n_checks++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL amo_release: got d_gnt=%b exp 1", d_gnt); end
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      next_cycle();
   endtask

   task automatic test_lock_timeout;
      drive(1, 0, 1, 32'h40, 0, 4'hF, 0, 0, 0);
      @(negedge clk);
      n_checks++; if (c_gnt !== 1'b1) begin n_fail++; $display("FAIL to_rd: got c_gnt=%b exp 1", c_gnt); end
      next_cycle();
      for (int i = 1; i <= 8; i++) begin
         drive(0, 0, 0, 0, 0, 0, 1, 0, 32'h80);
         @(negedge clk);
         n_checks++; if (d_gnt !== 1'b0 || lock_err !== 1'b0) begin n_fail++; $display("FAIL to_wait[%0d]: got d_gnt=%b err=%b exp 0 0", i, d_gnt, lock_err); end
         next_cycle();
      end
      drive(1, 0, 0, 32'h100, 0, 4'hF, 1, 0, 32'h80);
      @(negedge clk);
      n_checks++; if (lock_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b exp 1", lock_err); end
      n_checks++; if (d_gnt !== 1'b1 || c_gnt !== 1'b0) begin n_fail++; $display("FAIL to_dgnt: got c=%b d=%b exp 0 1", c_gnt, d_gnt); end
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      n_checks++; if (lock_err !== 1'b0 || d_rvalid !== 1'b1) begin n_fail++; $display("FAIL to_after: got err=%b drv=%b exp 0 1", lock_err, d_rvalid); end
      next_cycle();
   endtask

   task automatic test_lock_starve;
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 32'h100, 0, 4'hF, 1, 0, 32'h80);
         next_cycle();
      end
      drive(1, 0, 1, 32'h40, 0, 4'hF, 1, 0, 32'h80);
      @(negedge clk);
      n_checks++; if (d_gnt !== 1'b1 || c_gnt !== 1'b0) begin n_fail++; $display("FAIL ls_dwins: got c=%b d=%b exp 0 1", c_gnt, d_gnt); end
      next_cycle();
      drive(1, 0, 0, 32'h100, 0, 4'hF, 1, 0, 32'h80);
      @(negedge clk);
      n_checks++; if (c_gnt !== 1'b1) begin n_fail++; $display("FAIL ls_cwins: got c_gnt=%b exp 1", c_gnt); end
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 1, 0, 32'h80);
      @(negedge clk);
      n_checks++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL ls_nolock: got d_gnt=%b exp 1", d_gnt); end
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      next_cycle();
   endtask

   task automatic test_reset_inflight;
      drive(0, 0, 0, 0, 0, 0, 1, 0, 32'h80);
      @(negedge clk);
      n_checks++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL ri_gnt: got d_gnt=%b exp 1", d_gnt); end
      next_cycle();
      rst = 1'b1;
      drive(1, 0, 0, 32'h100, 0, 4'hF, 1, 0, 32'h80);
      @(negedge clk);
      n_checks++; if (d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin n_fail++; $display("FAIL ri_rvalid: got rv=%b data=%h exp 0 0", d_rvalid, d_rdata); end
      n_checks++; if (c_gnt !== 1'b0 || d_gnt !== 1'b0 || m_en !== 1'b0 || m_addr !== 32'h0 || lock_err !== 1'b0) begin n_fail++; $display("FAIL ri_outs: got c=%b d=%b en=%b addr=%h err=%b exp all 0", c_gnt, d_gnt, m_en, m_addr, lock_err); end
      next_cycle();
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 1, 0, 32'h80);
      @(negedge clk);
      n_checks++; if (d_gnt !== 1'b1 || m_addr !== 32'h80) begin n_fail++; $display("FAIL ri_resume: got d_gnt=%b addr=%h exp 1 00000080", d_gnt, m_addr); end
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      n_checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hC0FFEE20) begin n_fail++; $display("FAIL ri_data: got rv=%b data=%h exp 1 c0ffee20", d_rvalid, d_rdata); end
      next_cycle();
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_read();
      test_write_mask();
      test_starve();
      test_amo();
      test_lock_timeout();
      test_lock_starve();
      test_reset_inflight();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
